// File: rtl/sparc_alu_pkg.sv
// Shared definitions for the mini_alu result path: opcodes, icc bit positions, default width.
package sparc_alu_pkg;

  localparam int unsigned DefaultDataW = 32;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_ADDX  = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SUBX  = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_ANDN  = 4'b0111;
  localparam logic [3:0] OP_ORN   = 4'b1000;
  localparam logic [3:0] OP_XNOR  = 4'b1001;
  localparam logic [3:0] OP_SLL   = 4'b1010;
  localparam logic [3:0] OP_SRL   = 4'b1011;
  localparam logic [3:0] OP_SRA   = 4'b1100;
  localparam logic [3:0] OP_PASSA = 4'b1101;
  localparam logic [3:0] OP_PASSB = 4'b1110;
  localparam logic [3:0] OP_NOTB  = 4'b1111;

  localparam int unsigned ICC_N = 3;
  localparam int unsigned ICC_Z = 2;
  localparam int unsigned ICC_V = 1;
  localparam int unsigned ICC_C = 0;

endpackage

// File: rtl/icc_calc.sv
// Combinational SPARC icc generation {N,Z,V,C} from an ALU op, its operands and result.
module icc_calc
  import sparc_alu_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] y,
  input  logic              cin,
  output logic [3:0]        flags
);

  logic              cin_eff;
  logic [DATA_W:0]   a_ext;
  logic [DATA_W:0]   b_ext;
  logic [DATA_W:0]   cin_ext;
  logic [DATA_W:0]   max_ext;
  logic              sa;
  logic              sb;
  logic              sy;

  // Only the extended-precision forms consume the incoming carry.
  assign cin_eff = ((opcode == OP_ADDX) || (opcode == OP_SUBX)) ? cin : 1'b0;
  assign a_ext   = {1'b0, a};
  assign b_ext   = {1'b0, b};
  assign cin_ext = {{DATA_W{1'b0}}, cin_eff};
  assign max_ext = {1'b0, {DATA_W{1'b1}}};
  assign sa      = a[DATA_W-1];
  assign sb      = b[DATA_W-1];
  assign sy      = y[DATA_W-1];

  always_comb begin
    flags        = 4'b0000;
    flags[ICC_N] = sy;
    flags[ICC_Z] = (y == '0);
    case (opcode)
      OP_ADD, OP_ADDX: begin
        // Carry-out is whether the wide sum exceeds the largest DATA_W-bit value.
        flags[ICC_C] = (a_ext + b_ext + cin_ext) > max_ext;
        flags[ICC_V] = (sa == sb) && (sy != sa);
      end
      OP_SUB, OP_SUBX: begin
        flags[ICC_C] = a_ext < (b_ext + cin_ext);
        flags[ICC_V] = (sa != sb) && (sy != sa);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU result buffer with architectural icc register; flags update at accept, results drain in order.
module alu_writeback
  import sparc_alu_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_y,
  input  logic [4:0]        in_rd,
  input  logic              in_setcc,
  output logic              alu_c1,
  output logic [3:0]        icc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rd,
  output logic              out_we
);

  localparam int unsigned    PtrW    = $clog2(DEPTH);
  localparam int unsigned    CntW    = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [4:0]        rd_mem   [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q,  count_d;
  logic [3:0]      icc_q,    icc_d;
  logic [3:0]      icc_new;
  logic            push;
  logic            pop;

  icc_calc #(
    .DATA_W (DATA_W)
  ) u_icc_calc (
    .opcode (in_opcode),
    .a      (in_a),
    .b      (in_b),
    .y      (in_y),
    .cin    (icc_q[ICC_C]),
    .flags  (icc_new)
  );

  // in_ready depends only on registered count, never on out_ready.
  assign in_ready  = (count_q != CntFull);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = data_mem[rd_ptr_q];
  assign out_rd    = rd_mem[rd_ptr_q];
  assign out_we    = out_valid && (out_rd != 5'd0);
  assign icc       = icc_q;
  assign alu_c1    = icc_q[ICC_C];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    icc_d    = icc_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (in_setcc) begin
        icc_d = icc_new;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      icc_q    <= 4'b0000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      icc_q    <= icc_d;
    end
  end

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge Clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= in_y;
      rd_mem[wr_ptr_q]   <= in_rd;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed, table-driven bench for alu_writeback with hand-computed icc and drain expectations.
module tb_alu_writeback;

  logic        Clk;
  logic        Clr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_y;
  logic [4:0]  in_rd;
  logic        in_setcc;
  logic        alu_c1;
  logic [3:0]  icc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_we;

  int n_vec;
  int n_bad;

  alu_writeback #(
    .DATA_W (32),
    .DEPTH  (2)
  ) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_y      (in_y),
    .in_rd     (in_rd),
    .in_setcc  (in_setcc),
    .alu_c1    (alu_c1),
    .icc       (icc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_we    (out_we)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [4:0]  rd;
    logic        setcc;
    logic [3:0]  exp_icc;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] y, input logic [4:0] rd, input logic setcc);
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_y      = y;
    in_rd     = rd;
    in_setcc  = setcc;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_setcc = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    // icc values follow in order; ADDX/SUBX carry-in is the previous row's C.
    vecs[0]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd1,  1'b1, 4'b0101};
    vecs[1]  = '{4'b0010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'd2,  1'b1, 4'b0010};
    vecs[2]  = '{4'b0010, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 5'd3,  1'b1, 4'b1001};
    vecs[3]  = '{4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd4,  1'b1, 4'b1001};
    vecs[4]  = '{4'b0001, 32'h00000000, 32'h00000000, 32'h00000001, 5'd5,  1'b1, 4'b0000};
    vecs[5]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'd6,  1'b1, 4'b1010};
    vecs[6]  = '{4'b0101, 32'h000000F0, 32'h0000000F, 32'h000000FF, 5'd7,  1'b0, 4'b1010};
    vecs[7]  = '{4'b0101, 32'h00000000, 32'h00000000, 32'h00000000, 5'd0,  1'b1, 4'b0100};
    vecs[8]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd9,  1'b1, 4'b0101};
    vecs[9]  = '{4'b1010, 32'h80000000, 32'h00000001, 32'h00000000, 5'd10, 1'b1, 4'b0100};
    vecs[10] = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd11, 1'b1, 4'b0101};
    vecs[11] = '{4'b0011, 32'h00000005, 32'h00000005, 32'hFFFFFFFF, 5'd12, 1'b1, 4'b1001};
    vecs[12] = '{4'b0011, 32'h00000005, 32'h00000003, 32'h00000001, 5'd13, 1'b1, 4'b0000};
    vecs[13] = '{4'b0001, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 5'd14, 1'b1, 4'b1000};
    vecs[14] = '{4'b0011, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 5'd15, 1'b1, 4'b0001};
    vecs[15] = '{4'b0011, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 5'd16, 1'b1, 4'b0101};
    vecs[16] = '{4'b0001, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 5'd17, 1'b1, 4'b0101};

    Clr       = 1'b0;
    in_valid  = 1'b0;
    in_opcode = 4'b0000;
    in_a      = '0;
    in_b      = '0;
    in_y      = '0;
    in_rd     = '0;
    in_setcc  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    Clr = 1'b1;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_we", 32'(out_we), 32'd0);
    chk("rst_icc", 32'(icc), 32'd0);
    chk("rst_alu_c1", 32'(alu_c1), 32'd0);

    // One op per cycle, each drained the cycle after it lands.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].rd, vecs[i].setcc);
      step();
      idle();
      chk($sformatf("v%0d_icc", i), 32'(icc), 32'(vecs[i].exp_icc));
      chk($sformatf("v%0d_c1", i), 32'(alu_c1), 32'(vecs[i].exp_icc[0]));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_data", i), out_data, vecs[i].y);
      chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_we", i), 32'(out_we), 32'(vecs[i].rd != 5'd0));
    end
    step();
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Backpressure: two entries fill the buffer, a third attempt is refused.
    out_ready = 1'b0;
    drive(4'b0101, 32'h0, 32'h0, 32'h00000333, 5'd3, 1'b0);
    step();
    chk("bp_ready_after1", 32'(in_ready), 32'd1);
    drive(4'b0101, 32'h0, 32'h0, 32'h00000444, 5'd4, 1'b0);
    step();
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    drive(4'b0010, 32'h1, 32'h2, 32'hFFFFFFFF, 5'd5, 1'b1);
    step();
    chk("bp_held_icc", 32'(icc), 32'h5);
    chk("bp_held_ready", 32'(in_ready), 32'd0);
    idle();
    out_ready = 1'b1;
    chk("bp_head3_rd", 32'(out_rd), 32'd3);
    chk("bp_head3_data", out_data, 32'h00000333);
    step();
    chk("bp_head4_rd", 32'(out_rd), 32'd4);
    drive(4'b0101, 32'h0, 32'h0, 32'h00000555, 5'd5, 1'b0);
    step();
    chk("bp_head5_rd", 32'(out_rd), 32'd5);
    chk("bp_head5_valid", 32'(out_valid), 32'd1);
    drive(4'b0101, 32'h0, 32'h0, 32'h00000AAA, 5'd0, 1'b0);
    step();
    idle();
    chk("g0_valid", 32'(out_valid), 32'd1);
    chk("g0_we", 32'(out_we), 32'd0);
    chk("g0_data", out_data, 32'h00000AAA);
    step();
    chk("g0_drained", 32'(out_valid), 32'd0);

    // Full throughput: accept and drain every cycle.
    for (int k = 0; k < 4; k++) begin
      drive(4'b0101, 32'h0, 32'h0, 32'(k + 32'h100), 5'(20 + k), 1'b0);
      step();
      chk($sformatf("tp%0d_rd", k), 32'(out_rd), 32'(20 + k));
      chk($sformatf("tp%0d_ready", k), 32'(in_ready), 32'd1);
    end
    idle();
    step();

    // Mid-stream reset with two entries queued and a push on the reset cycle.
    out_ready = 1'b0;
    drive(4'b0101, 32'h0, 32'h0, 32'h00000888, 5'd8, 1'b0);
    step();
    drive(4'b0101, 32'h0, 32'h0, 32'h00000999, 5'd9, 1'b0);
    step();
    chk("pre_rst_icc", 32'(icc), 32'h5);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    Clr = 1'b0;
    drive(4'b0010, 32'h1, 32'h2, 32'hFFFFFFFF, 5'd10, 1'b1);
    step();
    Clr = 1'b1;
    idle();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_icc", 32'(icc), 32'd0);
    chk("mid_rst_c1", 32'(alu_c1), 32'd0);
    chk("mid_rst_we", 32'(out_we), 32'd0);
    out_ready = 1'b1;
    drive(4'b0000, 32'h00001233, 32'h00000001, 32'h00001234, 5'd7, 1'b1);
    step();
    idle();
    chk("post_rst_data", out_data, 32'h00001234);
    chk("post_rst_rd", 32'(out_rd), 32'd7);
    chk("post_rst_icc", 32'(icc), 32'd0);
    step();
    chk("post_rst_drained", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Result-side companion to `mini_alu`. It sits on the ALU output and does three jobs:

- Captures each ALU result together with its operands and destination register.
- Computes the SPARC integer condition codes (icc: N, Z, V, C) and holds them in an architectural register.
- Returns the carry bit to the ALU `c1` input, which closes the ADDX/SUBX loop.

Results are queued in a small buffer and drained to register-file writeback through a valid/ready handshake, so writeback stalls do not corrupt flag ordering.

## Interface
Parameters:
- `DATA_W`, 32: datapath width.
- `DEPTH`, 2: result buffer entries (power of two, ≥2).

Ports:
- `Clk`  in  1  single clock; all state changes on posedge.
- `Clr`  in  1  reset, synchronous, active-low. Taken on the posedge where `Clr`=0.
- `in_valid`  in  1  ALU result present this cycle.
- `in_ready`  out  1  block can accept; equals `count != DEPTH`, with no combinational path from `out_ready`.
- `in_opcode`  in  4  `mini_alu` opcode that produced the result.
- `in_a`, `in_b`  in  DATA_W  ALU operands, needed for C/V.
- `in_y`  in  DATA_W  ALU result.
- `in_rd`  in  5  destination register.
- `in_setcc`  in  1  update icc with this result.
- `alu_c1`  out  1  equals `icc[0]` (C), registered; drives ALU `c1`.
- `icc`  out  4  {N,Z,V,C}.
- `out_valid`  out  1  buffer non-empty.
- `out_ready`  in  1  writeback accepts.
- `out_data`  out  DATA_W  head entry result.
- `out_rd`  out  5  head entry rd.
- `out_we`  out  1  `out_valid && out_rd != 0`; writes to %g0 are suppressed but still drained.

## Operation
- **Accept:** push when `in_valid && in_ready`. Entry {y, rd} is written at the write pointer.
- **Flags** are computed from the accepted inputs, using the icc value current that cycle:
  - N = y[31].
  - Z = (y == 0).
  - Opcodes 0000/0001 (add/addx): C = bit 32 of {0,a}+{0,b}+cin, where cin = C for 0001 and 0 for 0000. V = (a[31]==b[31]) && (y[31]!=a[31]).
  - Opcodes 0010/0011 (sub/subx): C = borrow, i.e. {0,a} < {0,b}+cin. V = (a[31]!=b[31]) && (y[31]!=a[31]).
  - All other opcodes: C=0, V=0.
- **icc update:** icc takes the new flags on an accepted push with `in_setcc`=1. Otherwise icc holds.
- **Flag ordering:** icc updates at accept time, not at drain. Flag order therefore equals issue order regardless of writeback stalls.
- **Drain:** pop when `out_valid && out_ready`. Output is FIFO order and the head is presented combinationally from storage.
- **Occupancy:** `count`, with read and write pointers `$clog2(DEPTH)` bits wide that wrap modulo DEPTH.
  - Push+pop in the same cycle: count unchanged. This is legal at any count except 0 (no pop possible) and DEPTH (no push possible).
  - Full (count=DEPTH): `in_ready`=0. An `in_valid` that cycle is not accepted and icc is unaffected.
  - Empty: `out_valid`=0, `out_we`=0, and `out_data`/`out_rd` are don't-care.
- **Reset** (`Clr`=0 at posedge, including mid-stream):
  - count=0 and both pointers 0, so `out_valid`=0 and `in_ready`=1 next cycle.
  - icc=4'b0000, so `alu_c1`=0.
  - Pending entries are discarded.
  - Inputs on the reset cycle are ignored.
  - Buffer data RAM is not cleared.

## Timing
- Accept to `out_valid`: 1 cycle when the buffer was empty.
- Accept with setcc to new `icc`/`alu_c1` visible: 1 cycle. Back-to-back ADDX therefore sees the previous op's carry.
- Full throughput: one accept and one drain per cycle when `out_ready`=1.
- Reset values: `in_ready`=1, `out_valid`=0, `out_we`=0, `icc`=0, `alu_c1`=0.

## Structure
- Shared package `sparc_alu_pkg`:
  - ALU opcode constants (OP_ADD=4'b0000, OP_ADDX, OP_SUB, OP_SUBX, …, OP_NOTB=4'b1111).
  - icc bit indices ICC_N=3, ICC_Z=2, ICC_V=1, ICC_C=0.
  - DATA_W default.
- Sub-module `icc_calc`: combinational flag generation (opcode, a, b, y, cin → {N,Z,V,C}). It is reusable by a future branch unit.
- The top level holds the FIFO storage, pointers, count and icc register.

## Test plan
- **Add carry:** reset, then accept op 0000, a=0xFFFFFFFF, b=1, y=0, setcc=1. Next cycle icc=4'b0101 and `alu_c1`=1. `out_data`=0.
- **Sub overflow:** op 0010, a=0x80000000, b=1, y=0x7FFFFFFF, setcc=1. Required icc=4'b0010 (V only).
- **Sub borrow:** op 0010, a=1, b=2, y=0xFFFFFFFF. Required icc=4'b1001.
- **Addx chain:**
  - First op 0000, a=0xFFFFFFFF, b=0xFFFFFFFF, y=0xFFFFFFFE, setcc=1, giving C=1.
  - Next cycle op 0001, a=0, b=0, y=1, setcc=1.
  - Required: icc=4'b0000 after the second op, and `alu_c1`=1 between the two ops.
- **Backpressure:**
  - Hold `out_ready`=0 and push rd=3,4,5.
  - Required: `in_ready`=0 after two accepts, so the third is held.
  - Raise `out_ready`: outputs rd 3,4,5 in order. Then push rd=0: `out_valid`=1 with `out_we`=0.
- **setcc=0 and reset:**
  - Accept a logical op (0101) with setcc=0: icc unchanged.
  - With 2 entries queued, drive `Clr`=0 for one cycle.
  - Required next cycle: `out_valid`=0, `in_ready`=1, icc=0.
